// File: rtl/pong_referee_pkg.sv
// ---------------------------------------------------------------------------
// pong_referee_pkg
//   Shared definitions for the pong referee and its collision helper:
//   - bounce codes sent to the ball FSM (none / paddle / wall / scored)
//   - referee FSM state encodings (SERVE, PLAY, OVER)
//   - default screen dimensions
//   - edge_sum(): widens a position plus a size to 11 bits so that edge
//     compares never wrap
// ---------------------------------------------------------------------------
package pong_referee_pkg;

    localparam logic [1:0] BOUNCE_NONE   = 2'b00;
    localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
    localparam logic [1:0] BOUNCE_WALL   = 2'b10;
    localparam logic [1:0] BOUNCE_SCORE  = 2'b11;

    localparam logic [1:0] ST_SERVE = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;

    localparam int SCREEN_X_DEF = 640;
    localparam int SCREEN_Y_DEF = 480;

    // Far edge of an object (left/top edge plus width/height), one bit wider
    // than the position so the sum cannot overflow.
    function automatic logic [10:0] edge_sum(input logic [9:0] pos, input logic [7:0] size);
        return {1'b0, pos} + {3'b000, size};
    endfunction

endpackage

// File: rtl/pong_referee_hit_detect.sv
// ---------------------------------------------------------------------------
// pong_referee_hit_detect
//   Combinational axis-aligned bounding-box overlap between the ball and one
//   paddle. Overlap is strict: touching edges do not count as a hit.
// Ports
//   ball_x, ball_y  in  10  ball left / top edge
//   ball_w, ball_h  in  8   ball width / height
//   pad_y           in  10  paddle top edge (paddle x is the PAD_X parameter)
//   hit             out 1   ball and paddle rectangles overlap
// ---------------------------------------------------------------------------
module pong_referee_hit_detect
    import pong_referee_pkg::*;
#(
    parameter int PAD_X    = 20,
    parameter int PADDLE_W = 10,
    parameter int PADDLE_H = 60
) (
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_w,
    input  logic [7:0] ball_h,
    input  logic [9:0] pad_y,
    output logic       hit
);

    localparam logic [10:0] PAD_L = 11'(PAD_X);
    localparam logic [10:0] PAD_R = 11'(PAD_X + PADDLE_W);

    logic [10:0] ball_r;
    logic [10:0] ball_b;
    logic [10:0] pad_b;
    logic        x_overlap;
    logic        y_overlap;

    assign ball_r = edge_sum(ball_x, ball_w);
    assign ball_b = edge_sum(ball_y, ball_h);
    assign pad_b  = {1'b0, pad_y} + 11'(PADDLE_H);

    assign x_overlap = ({1'b0, ball_x} < PAD_R) && (ball_r > PAD_L);
    assign y_overlap = ({1'b0, ball_y} < pad_b) && (ball_b > {1'b0, pad_y});
    assign hit       = x_overlap && y_overlap;

endmodule

// File: rtl/pong_referee.sv
// ---------------------------------------------------------------------------
// pong_referee
//   Evaluates ball collisions once per tick and issues a registered 2-bit
//   bounce code to the ball FSM (00 none, 01 paddle, 10 wall, 11 scored).
//   Keeps both scores and sequences SERVE -> PLAY -> (SERVE | OVER).
// Ports
//   clock      in   1   system clock
//   reset      in   1   synchronous, active-high
//   tick       in   1   1-cycle evaluation strobe
//   ball_x/y   in   10  ball left / top edge
//   ball_w/h   in   8   ball width / height
//   pad1_y     in   10  left paddle top edge
//   pad2_y     in   10  right paddle top edge
//   bounce     out  2   bounce code, 1-cycle pulse the cycle after a tick
//   score1/2   out  4   left / right player score
//   serving    out  1   high in SERVE
//   game_over  out  1   high in OVER
// ---------------------------------------------------------------------------
module pong_referee
    import pong_referee_pkg::*;
#(
    parameter int SCREEN_X    = SCREEN_X_DEF,
    parameter int SCREEN_Y    = SCREEN_Y_DEF,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_H    = 60,
    parameter int P1_X        = 20,
    parameter int P2_X        = 610,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 60,
    parameter int COOLDOWN    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_w,
    input  logic [7:0] ball_h,
    input  logic [9:0] pad1_y,
    input  logic [9:0] pad2_y,
    output logic [1:0] bounce,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       serving,
    output logic       game_over
);

    localparam logic [10:0] SX        = 11'(SCREEN_X);
    localparam logic [10:0] SY        = 11'(SCREEN_Y);
    localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
    localparam logic [3:0]  CD_LOAD   = 4'(COOLDOWN);
    localparam logic [7:0]  SERVE_END = 8'(SERVE_DELAY - 1);

    logic [1:0] state, state_n;
    logic [7:0] serve_cnt, serve_cnt_n;
    logic [3:0] pad_cd, pad_cd_n, pad_cd_dec;
    logic [3:0] wall_cd, wall_cd_n, wall_cd_dec;
    logic [3:0] score1_n, score2_n;
    logic [1:0] bounce_n;
    logic       hit1, hit2;
    logic       left_exit, right_exit, wall_hit;

    pong_referee_hit_detect #(.PAD_X(P1_X), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)) u_hit1 (
        .ball_x(ball_x), .ball_y(ball_y), .ball_w(ball_w), .ball_h(ball_h),
        .pad_y(pad1_y), .hit(hit1)
    );

    pong_referee_hit_detect #(.PAD_X(P2_X), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)) u_hit2 (
        .ball_x(ball_x), .ball_y(ball_y), .ball_w(ball_w), .ball_h(ball_h),
        .pad_y(pad2_y), .hit(hit2)
    );

    // A position at or past the screen edge is a ball that has wrapped below 0.
    assign left_exit  = (ball_x == 10'd0) || ({1'b0, ball_x} >= SX);
    assign right_exit = edge_sum(ball_x, ball_w) >= SX;
    assign wall_hit   = (ball_y == 10'd0) || ({1'b0, ball_y} >= SY) ||
                        (edge_sum(ball_y, ball_h) >= SY);

    // Cooldowns count down at the start of each PLAY tick and gate on the
    // decremented value, so a code suppressed at load COOLDOWN may repeat on
    // the COOLDOWN-th tick after it was issued.
    assign pad_cd_dec  = (pad_cd  != 4'd0) ? pad_cd  - 4'd1 : 4'd0;
    assign wall_cd_dec = (wall_cd != 4'd0) ? wall_cd - 4'd1 : 4'd0;

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that left one unassigned would infer a latch.
        state_n     = state;
        serve_cnt_n = serve_cnt;
        pad_cd_n    = pad_cd;
        wall_cd_n   = wall_cd;
        score1_n    = score1;
        score2_n    = score2;
        bounce_n    = BOUNCE_NONE;

        if (tick) begin
            case (state)
                ST_SERVE: begin
                    if (serve_cnt == SERVE_END) begin
                        state_n     = ST_PLAY;
                        serve_cnt_n = 8'd0;
                    end else begin
                        serve_cnt_n = serve_cnt + 8'd1;
                    end
                end
                ST_PLAY: begin
                    pad_cd_n  = pad_cd_dec;
                    wall_cd_n = wall_cd_dec;
                    if (left_exit || right_exit) begin
                        bounce_n  = BOUNCE_SCORE;
                        pad_cd_n  = 4'd0;
                        wall_cd_n = 4'd0;
                        if (left_exit) begin
                            score2_n = (score2 >= WIN) ? score2 : score2 + 4'd1;
                            state_n  = (score2_n == WIN) ? ST_OVER : ST_SERVE;
                        end else begin
                            score1_n = (score1 >= WIN) ? score1 : score1 + 4'd1;
                            state_n  = (score1_n == WIN) ? ST_OVER : ST_SERVE;
                        end
                    end else if ((hit1 || hit2) && (pad_cd_dec == 4'd0)) begin
                        bounce_n = BOUNCE_PADDLE;
                        pad_cd_n = CD_LOAD;
                    end else if (wall_hit && (wall_cd_dec == 4'd0)) begin
                        bounce_n  = BOUNCE_WALL;
                        wall_cd_n = CD_LOAD;
                    end
                end
                default: ;  // OVER: ticks are ignored until reset
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_SERVE;
            serve_cnt <= 8'd0;
            pad_cd    <= 4'd0;
            wall_cd   <= 4'd0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            bounce    <= BOUNCE_NONE;
        end else begin
            state     <= state_n;
            serve_cnt <= serve_cnt_n;
            pad_cd    <= pad_cd_n;
            wall_cd   <= wall_cd_n;
            score1    <= score1_n;
            score2    <= score2_n;
            bounce    <= bounce_n;
        end
    end

    assign serving   = (state == ST_SERVE);
    assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_pong_referee.sv
// ---------------------------------------------------------------------------
// tb_pong_referee
//   Self-checking bench for pong_referee with default parameters.
//   Expected bounce codes are queued when a tick is driven and popped when
//   the DUT's registered pulse appears one cycle later.
// ---------------------------------------------------------------------------
module tb_pong_referee;

    logic       clock;
    logic       reset;
    logic       tick;
    logic [9:0] ball_x, ball_y, pad1_y, pad2_y;
    logic [7:0] ball_w, ball_h;
    logic [1:0] bounce;
    logic [3:0] score1, score2;
    logic       serving, game_over;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [1:0] code;
    } exp_t;

    typedef struct {
        string      name;
        logic [9:0] bx, by, p1, p2;
        logic [7:0] bw, bh;
        logic [1:0] code;
    } vec_t;

    exp_t exp_q[$];
    vec_t vec_q[$];

    pong_referee dut (
        .clock(clock), .reset(reset), .tick(tick),
        .ball_x(ball_x), .ball_y(ball_y), .ball_w(ball_w), .ball_h(ball_h),
        .pad1_y(pad1_y), .pad2_y(pad2_y),
        .bounce(bounce), .score1(score1), .score2(score2),
        .serving(serving), .game_over(game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ball(input int x, input int y, input int w, input int h);
        ball_x = 10'(x);
        ball_y = 10'(y);
        ball_w = 8'(w);
        ball_h = 8'(h);
    endtask

    task automatic add_vec(input string name, input int x, input int y, input int w, input int h,
                           input int p1, input int p2, input logic [1:0] code);
        vec_t v;
        v.name = name;
        v.bx = 10'(x); v.by = 10'(y); v.bw = 8'(w); v.bh = 8'(h);
        v.p1 = 10'(p1); v.p2 = 10'(p2);
        v.code = code;
        vec_q.push_back(v);
    endtask

    // One tick: queue the expected code, strobe for one edge, compare the
    // pulse, then confirm it dropped back to 00 on the following cycle.
    task automatic do_tick(input string name, input logic [1:0] code);
        exp_t e;
        exp_t got;
        e.name = name;
        e.code = code;
        exp_q.push_back(e);
        tick = 1'b1;
        @(posedge clock); #1;
        tick = 1'b0;
        got = exp_q.pop_front();
        check(got.name, 32'(bounce), 32'(got.code));
        @(posedge clock); #1;
        check({got.name, "_hold"}, 32'(bounce), 32'd0);
    endtask

    task automatic neutral_ticks(input int n);
        set_ball(320, 240, 15, 15);
        for (int i = 0; i < n; i++) do_tick("neutral", 2'b00);
    endtask

    // Runs the SERVE period without moving the ball and checks it ends.
    task automatic serve_wait(input string name);
        for (int i = 0; i < 60; i++) begin
            tick = 1'b1;
            @(posedge clock); #1;
            tick = 1'b0;
            if (bounce !== 2'b00) check({name, "_serve_bounce"}, 32'(bounce), 32'd0);
            @(posedge clock); #1;
        end
        check({name, "_serve_done"}, 32'(serving), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick  = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        pad1_y = 10'd200;
        pad2_y = 10'd200;
        set_ball(320, 240, 15, 15);
        do_reset();

        check("rst_bounce",    32'(bounce),    32'd0);
        check("rst_score1",    32'(score1),    32'd0);
        check("rst_score2",    32'(score2),    32'd0);
        check("rst_serving",   32'(serving),   32'd1);
        check("rst_game_over", 32'(game_over), 32'd0);

        // Serve: 60 ticks, serving drops exactly on the 60th.
        for (int i = 0; i < 60; i++) begin
            do_tick("serve_tick", 2'b00);
            check($sformatf("serve_serving_%0d", i), 32'(serving), (i == 59) ? 32'd0 : 32'd1);
        end

        // Single-tick PLAY vectors, cooldowns expired between each.
        add_vec("center",         320, 240, 15, 15, 200, 200, 2'b00);
        add_vec("top_wall",       300,   0, 15, 15, 200, 200, 2'b10);
        add_vec("bottom_wall",    300, 465, 15, 15, 200, 200, 2'b10);
        add_vec("above_bottom",   300, 464, 15, 15, 200, 200, 2'b00);
        add_vec("y_underflow",    300,1000, 15, 15, 200, 200, 2'b10);
        add_vec("left_paddle",     25, 220, 15, 15, 200, 200, 2'b01);
        add_vec("left_pad_moved",  25, 220, 15, 15, 300, 200, 2'b00);
        add_vec("right_paddle",   600, 220, 15, 15, 300, 200, 2'b01);
        add_vec("pad_top_touch",   25, 185, 15, 15, 200, 200, 2'b00);
        add_vec("pad_top_overlap", 25, 186, 15, 15, 200, 200, 2'b01);
        add_vec("pad_bottom_touch",25, 260, 15, 15, 200, 200, 2'b00);
        add_vec("pad_right_touch", 30, 220, 15, 15, 200, 200, 2'b00);
        add_vec("pad_left_touch",   5, 220, 15, 15, 200, 200, 2'b00);
        add_vec("pad_left_overlap", 5, 220, 16, 15, 200, 200, 2'b01);

        foreach (vec_q[i]) begin
            set_ball(int'(vec_q[i].bx), int'(vec_q[i].by), int'(vec_q[i].bw), int'(vec_q[i].bh));
            pad1_y = vec_q[i].p1;
            pad2_y = vec_q[i].p2;
            do_tick(vec_q[i].name, vec_q[i].code);
            pad1_y = 10'd200;
            pad2_y = 10'd200;
            neutral_ticks(4);
        end

        // Wall cooldown: 10, then three suppressed ticks, then 10 again.
        set_ball(300, 0, 15, 15);
        do_tick("cd_wall_1", 2'b10);
        do_tick("cd_wall_2", 2'b00);
        do_tick("cd_wall_3", 2'b00);
        do_tick("cd_wall_4", 2'b00);
        do_tick("cd_wall_5", 2'b10);
        neutral_ticks(4);

        // Paddle and wall on the same tick: paddle first, wall next.
        pad1_y = 10'd0;
        set_ball(25, 0, 15, 15);
        do_tick("corner_paddle", 2'b01);
        do_tick("corner_wall",   2'b10);
        do_tick("corner_quiet",  2'b00);
        pad1_y = 10'd200;
        neutral_ticks(4);

        // Scoring.
        set_ball(1023, 240, 15, 15);
        do_tick("left_underflow", 2'b11);
        check("underflow_score2",  32'(score2),  32'd1);
        check("underflow_serving", 32'(serving), 32'd1);
        serve_wait("after_underflow");

        set_ball(630, 240, 15, 15);
        do_tick("right_exit", 2'b11);
        check("right_score1",  32'(score1),  32'd1);
        check("right_serving", 32'(serving), 32'd1);
        serve_wait("after_right");

        set_ball(0, 240, 15, 15);
        do_tick("left_zero", 2'b11);
        check("zero_score2", 32'(score2), 32'd2);
        serve_wait("after_zero");

        set_ball(630, 240, 15, 15);
        for (int k = 2; k <= 8; k++) begin
            do_tick($sformatf("run_exit_%0d", k), 2'b11);
            check($sformatf("run_score1_%0d", k), 32'(score1), 32'(k));
            check($sformatf("run_over_%0d", k), 32'(game_over), 32'd0);
            serve_wait($sformatf("run_%0d", k));
        end

        do_tick("winning_exit", 2'b11);
        check("win_score1",    32'(score1),    32'd9);
        check("win_game_over", 32'(game_over), 32'd1);
        check("win_serving",   32'(serving),   32'd0);
        for (int i = 0; i < 10; i++) do_tick("over_ignored", 2'b00);
        check("over_score1", 32'(score1), 32'd9);
        check("over_score2", 32'(score2), 32'd2);
        check("over_still",  32'(game_over), 32'd1);

        do_reset();
        check("rst2_bounce",    32'(bounce),    32'd0);
        check("rst2_score1",    32'(score1),    32'd0);
        check("rst2_score2",    32'(score2),    32'd0);
        check("rst2_serving",   32'(serving),   32'd1);
        check("rst2_game_over", 32'(game_over), 32'd0);

        // Reset on the same edge a wall pulse would be produced.
        set_ball(320, 240, 15, 15);
        serve_wait("pre_reset_drop");
        set_ball(300, 0, 15, 15);
        tick  = 1'b1;
        reset = 1'b1;
        @(posedge clock); #1;
        tick  = 1'b0;
        reset = 1'b0;
        check("reset_drop_bounce",  32'(bounce),  32'd0);
        check("reset_drop_serving", 32'(serving), 32'd1);
        @(posedge clock); #1;
        check("reset_drop_after", 32'(bounce), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
